instruction_fetch: RTL and testbench

//  Fetch stage feeding decode. Owns the PC and drives the word address of the synchronous instruction

---
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Fetch stage: owns the PC, drives a 1-cycle-latency instruction
//             memory, buffers returned words in a 2-entry FIFO and hands
//             {pc, instr} to decode over valid/ready, with redirect + flush.
//  Options  : FETCH_PERF_EN adds saturating pop/stall performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_FETCH = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;

    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_data [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [2:0]  w_occ;
    logic        w_unused_lsb;

    assign w_unused_lsb = ^redirect_pc[1:0];

    assign inst_valid = (r_count != 2'd0);
    assign inst_data  = r_fifo_data[r_rd_ptr];
    assign inst_pc    = r_fifo_pc[r_rd_ptr];
    assign imem_addr  = {{(32-IDX_W){1'b0}}, r_fetch_pc[IDX_W+1:2]};

    assign w_pop  = inst_valid & inst_ready;
    assign w_push = r_inflight & ~redirect_valid;
    // Occupancy after this edge, counting the word still in memory's pipeline.
    assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == c_FETCH) & fetch_en & ~redirect_valid & (w_occ < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
        end else begin
            case (r_state)
                c_IDLE:  if (fetch_en)  r_state <= c_FETCH;
                c_FETCH: if (!fetch_en) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase

            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_inflight <= 1'b0;
            end else if (w_issue) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end else begin
                r_inflight <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_pc[0]   <= 32'h0;
            r_fifo_pc[1]   <= 32'h0;
            r_fifo_data[0] <= 32'h0;
            r_fifo_data[1] <= 32'h0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else if (redirect_valid) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
                r_fifo_data[r_wr_ptr] <= imem_rdata;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_pop && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (inst_valid && !inst_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Directed vector bench for instruction_fetch with a synchronous
//             memory model preloaded with a short program.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instruction_fetch #(
        .RESET_PC   (32'h0),
        .IMEM_DEPTH (256)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

    typedef struct packed {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] edata;
        logic [31:0] eaddr;
    } vec_t;

    localparam int NV = 31;
    vec_t vt [NV];

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(logic en, logic rdy, logic redir, logic [31:0] rpc,
                                logic ev, logic [31:0] epc, logic [31:0] edata,
                                logic [31:0] eaddr);
        vec_t v;
        v.en = en; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.edata = edata; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0050_0093; mem[1] = 32'h0080_0113; mem[2] = 32'h0100_0193;
        mem[3] = 32'h0000_8233; mem[4] = 32'h0021_02b3; mem[5] = 32'h0031_8333;

        // Startup, then stall with head at 0x0C for five cycles.
        vt[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 1, 0, 0, 0, 0, 0, 1);
        vt[2]  = mk(1, 1, 0, 0, 1, 32'h00, 32'h0050_0093, 2);
        vt[3]  = mk(1, 1, 0, 0, 1, 32'h04, 32'h0080_0113, 3);
        vt[4]  = mk(1, 1, 0, 0, 1, 32'h08, 32'h0100_0193, 4);
        vt[5]  = mk(1, 1, 0, 0, 1, 32'h0C, 32'h0000_8233, 5);
        for (int i = 6; i <= 10; i++) vt[i] = mk(1, 0, 0, 0, 1, 32'h0C, 32'h0000_8233, 5);
        vt[11] = mk(1, 1, 0, 0, 1, 32'h10, 32'h0021_02b3, 6);
        vt[12] = mk(1, 1, 0, 0, 1, 32'h14, 32'h0031_8333, 7);
        vt[13] = mk(1, 1, 0, 0, 1, 32'h18, 32'hA000_0006, 8);
        vt[14] = mk(1, 1, 0, 0, 1, 32'h1C, 32'hA000_0007, 9);
        vt[15] = mk(1, 1, 0, 0, 1, 32'h20, 32'hA000_0008, 10);
        vt[16] = mk(1, 1, 0, 0, 1, 32'h24, 32'hA000_0009, 11);
        vt[17] = mk(1, 1, 0, 0, 1, 32'h28, 32'hA000_000A, 12);
        // Redirect to 0 while head is 0x28.
        vt[18] = mk(1, 1, 1, 32'h0, 0, 0, 0, 0);
        vt[19] = mk(1, 1, 0, 0, 0, 0, 0, 1);
        vt[20] = mk(1, 1, 0, 0, 1, 32'h00, 32'h0050_0093, 2);
        // Misaligned redirect near the top of memory, then index wrap.
        vt[21] = mk(1, 1, 1, 32'h3FE, 0, 0, 0, 32'hFF);
        vt[22] = mk(1, 1, 0, 0, 0, 0, 0, 0);
        vt[23] = mk(1, 1, 0, 0, 1, 32'h3FC, 32'hA000_00FF, 1);
        vt[24] = mk(1, 1, 0, 0, 1, 32'h400, 32'h0050_0093, 2);
        // fetch_en dropped: in-flight word still arrives, then resume.
        vt[25] = mk(0, 1, 0, 0, 1, 32'h404, 32'h0080_0113, 2);
        vt[26] = mk(0, 1, 0, 0, 0, 0, 0, 2);
        vt[27] = mk(1, 1, 0, 0, 0, 0, 0, 2);
        vt[28] = mk(1, 1, 0, 0, 0, 0, 0, 3);
        vt[29] = mk(1, 1, 0, 0, 1, 32'h408, 32'h0100_0193, 4);
        vt[30] = mk(1, 0, 0, 0, 1, 32'h408, 32'h0100_0193, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", -1, {31'h0, inst_valid}, 32'h0);
        chk("reset_pc",    -1, inst_pc,   32'h0);
        chk("reset_data",  -1, inst_data, 32'h0);
        chk("reset_addr",  -1, imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("reset_perf_fetch", -1, perf_fetch_cnt, 32'h0);
        chk("reset_perf_stall", -1, perf_stall_cnt, 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            fetch_en       = vt[i].en;
            inst_ready     = vt[i].rdy;
            redirect_valid = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            @(posedge clk);
            #1;
            chk("valid", i, {31'h0, inst_valid}, {31'h0, vt[i].ev});
            chk("addr",  i, imem_addr, vt[i].eaddr);
            if (vt[i].ev) begin
                chk("pc",   i, inst_pc,   vt[i].epc);
                chk("data", i, inst_data, vt[i].edata);
            end
`ifdef FETCH_PERF_EN
            if (i == 10) chk("perf_stall_5", i, perf_stall_cnt, 32'd5);
`endif
        end
        redirect_valid = 1'b0;

`ifdef FETCH_PERF_EN
        chk("perf_fetch_end", NV, perf_fetch_cnt, 32'd15);
        chk("perf_stall_end", NV, perf_stall_cnt, 32'd6);
`endif

        // Asynchronous reset with the FIFO full.
        rst_n = 1'b0;
        #1;
        chk("areset_valid", 100, {31'h0, inst_valid}, 32'h0);
        chk("areset_pc",    100, inst_pc,   32'h0);
        chk("areset_data",  100, inst_data, 32'h0);
        chk("areset_addr",  100, imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("areset_perf", 100, perf_fetch_cnt, 32'h0);
`endif
        @(negedge clk);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        rst_n      = 1'b1;
        @(posedge clk); #1;
        chk("restart_valid1", 101, {31'h0, inst_valid}, 32'h0);
        @(posedge clk); #1;
        chk("restart_valid2", 102, {31'h0, inst_valid}, 32'h0);
        chk("restart_addr2",  102, imem_addr, 32'h1);
        @(posedge clk); #1;
        chk("restart_valid3", 103, {31'h0, inst_valid}, 32'h1);
        chk("restart_pc3",    103, inst_pc,   32'h0);
        chk("restart_data3",  103, inst_data, 32'h0050_0093);
        @(posedge clk); #1;
        chk("restart_pc4",    104, inst_pc,   32'h4);
        chk("restart_data4",  104, inst_data, 32'h0080_0113);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
